// File: rtl/klima_zamanlayici.sv
// klima_zamanlayici: periodic temperature sampler and climate mode classifier.
// Requests a sample from the sensor every SAMPLE_PERIOD cycles, times out
// after TIMEOUT cycles without an ack, and moves a 4-way climate mode with
// hysteresis based on the (optionally averaged) temperature.
// Optional feature: define KLIMA_AVG_EN to average 4 samples per decision.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | schedule stopped, waiting for enable
// WAIT    | counting down the sample period
// REQUEST | sensor_req high, waiting for ack or timeout
// DECIDE  | sample set complete, mode/avg_temp update on exit
module klima_zamanlayici #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int TIMEOUT       = 64,
  parameter int LOW_TH        = 20,
  parameter int HIGH_TH       = 30,
  parameter int HYST          = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       sensor_req,
  input  logic       sensor_ack,
  input  logic [7:0] sensor_data,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic [7:0] avg_temp,
  output logic       sensor_fault
);

  typedef enum logic [1:0] {IDLE, WAIT, REQUEST, DECIDE} state_t;

  localparam logic [15:0] PER_LOAD = 16'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]  TMO_LOAD = 8'(TIMEOUT - 1);
  // Thresholds widened to 10 bits so -128/+127 plus hysteresis never wrap.
  localparam logic signed [9:0] LOW_S   = 10'(LOW_TH);
  localparam logic signed [9:0] HIGH_S  = 10'(HIGH_TH);
  localparam logic signed [9:0] LOW_UP  = 10'(LOW_TH + HYST);
  localparam logic signed [9:0] HIGH_DN = 10'(HIGH_TH - HYST);

  localparam logic [1:0] M_OFF  = 2'b00;
  localparam logic [1:0] M_COLD = 2'b01;
  localparam logic [1:0] M_COMF = 2'b10;
  localparam logic [1:0] M_HOT  = 2'b11;

  state_t state, state_nxt;
  logic [15:0] per_cnt;
  logic [7:0]  tmo_cnt;
  logic        ack_ok, tmo_hit, last_sample;
  logic signed [7:0] avg_cur;
  logic signed [9:0] avg_x;
  logic [1:0]  mode_nxt;

  // State register; async reset drops sensor_req immediately via the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, ack/timeout qualification and sensor request.
  always_comb begin
    state_nxt  = state;
    ack_ok     = 1'b0;
    tmo_hit    = 1'b0;
    sensor_req = (state == REQUEST);
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = WAIT;
        WAIT:    if (per_cnt == 16'd0) state_nxt = REQUEST;
        REQUEST: begin
          // An ack on the timeout cycle still counts as a good sample.
          if (sensor_ack) begin
            ack_ok    = 1'b1;
            state_nxt = last_sample ? DECIDE : WAIT;
          end else if (tmo_cnt == 8'd0) begin
            tmo_hit   = 1'b1;
            state_nxt = WAIT;
          end
        end
        DECIDE:  state_nxt = WAIT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Period and timeout down-counters, loaded on entry to their state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt <= 16'd0;
      tmo_cnt <= 8'd0;
    end else if (!enable) begin
      per_cnt <= 16'd0;
      tmo_cnt <= 8'd0;
    end else begin
      if (state_nxt == WAIT && state != WAIT)            per_cnt <= PER_LOAD;
      else if (state == WAIT && per_cnt != 16'd0)        per_cnt <= per_cnt - 16'd1;
      if (state_nxt == REQUEST && state != REQUEST)      tmo_cnt <= TMO_LOAD;
      else if (state == REQUEST && tmo_cnt != 8'd0)      tmo_cnt <= tmo_cnt - 8'd1;
    end
  end

`ifdef KLIMA_AVG_EN
  logic signed [9:0] acc;
  logic [1:0]        n_cnt;

  assign last_sample = (n_cnt == 2'd3);
  // Floor divide by 4 of the 10-bit signed sum.
  assign avg_cur     = acc[9:2];

  // Four-sample accumulator, emptied after each decision or on abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= 10'sd0;
      n_cnt <= 2'd0;
    end else if (!enable || tmo_hit || state == DECIDE) begin
      acc   <= 10'sd0;
      n_cnt <= 2'd0;
    end else if (ack_ok) begin
      acc   <= acc + $signed({{2{sensor_data[7]}}, sensor_data});
      n_cnt <= n_cnt + 2'd1;
    end
  end
`else
  logic signed [7:0] acc;

  assign last_sample = 1'b1;
  assign avg_cur     = acc;

  // Single-sample holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   acc <= 8'sd0;
    else if (!enable || tmo_hit) acc <= 8'sd0;
    else if (ack_ok)             acc <= sensor_data;
  end
`endif

  // Mode classification with hysteresis, all compares signed.
  always_comb begin
    avg_x    = {{2{avg_cur[7]}}, avg_cur};
    mode_nxt = mode;
    case (mode)
      M_OFF: begin
        if (avg_x <= LOW_S)       mode_nxt = M_COLD;
        else if (avg_x <= HIGH_S) mode_nxt = M_COMF;
        else                      mode_nxt = M_HOT;
      end
      M_COLD: begin
        if (avg_x > HIGH_S)       mode_nxt = M_HOT;
        else if (avg_x > LOW_UP)  mode_nxt = M_COMF;
      end
      M_COMF: begin
        if (avg_x <= LOW_S)       mode_nxt = M_COLD;
        else if (avg_x > HIGH_S)  mode_nxt = M_HOT;
      end
      default: begin
        if (avg_x <= LOW_S)       mode_nxt = M_COLD;
        else if (avg_x <= HIGH_DN) mode_nxt = M_COMF;
      end
    endcase
  end

  // Registered outputs: decision update, valid pulse and sticky fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode         <= M_OFF;
      mode_valid   <= 1'b0;
      avg_temp     <= 8'd0;
      sensor_fault <= 1'b0;
    end else begin
      mode_valid <= 1'b0;
      if (enable && state == DECIDE) begin
        mode       <= mode_nxt;
        avg_temp   <= avg_cur;
        mode_valid <= 1'b1;
      end
      if (tmo_hit) begin
        sensor_fault <= 1'b1;
        mode         <= M_OFF;
      end
      if (ack_ok) sensor_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_klima_zamanlayici.sv
// Directed bench for klima_zamanlayici with a decision scoreboard.
// Build with KLIMA_AVG_EN defined to exercise the 4-sample averaging build.
module tb_klima_zamanlayici;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       sensor_req;
  logic       sensor_ack;
  logic [7:0] sensor_data;
  logic [1:0] mode;
  logic       mode_valid;
  logic [7:0] avg_temp;
  logic       sensor_fault;

  typedef struct packed {
    logic [1:0] m;
    logic [7:0] a;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   n_valid = 0;

  klima_zamanlayici dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sensor_req   (sensor_req),
    .sensor_ack   (sensor_ack),
    .sensor_data  (sensor_data),
    .mode         (mode),
    .mode_valid   (mode_valid),
    .avg_temp     (avg_temp),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every mode_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && mode_valid) begin
      n_valid++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid observed=1 expected=0 mode=%0h avg=%0h", mode, avg_temp);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_mode", 32'(mode), 32'(e.m));
        chk("sb_avg", 32'(avg_temp), 32'(e.a));
      end
    end
  end

  task automatic wait_req();
    for (int i = 0; i < 1200 && !sensor_req; i++) begin
      @(negedge clk); #1;
    end
    chk("req_seen", 32'(sensor_req), 32'd1);
  endtask

  // Acks 3 cycles after the request; optionally expects a decision.
  task automatic do_sample(input logic [7:0] d, input logic push,
                           input logic [1:0] em, input logic [7:0] ea);
    int nv0;
    wait_req();
    repeat (2) @(negedge clk);
    if (push) sb.push_back('{m: em, a: ea});
    nv0 = n_valid;
    sensor_ack  = 1'b1;
    sensor_data = d;
    @(negedge clk);
    sensor_ack = 1'b0;
    #1;
    chk("req_drop_on_ack", 32'(sensor_req), 32'd0);
    if (push) begin
      for (int i = 0; i < 6 && n_valid == nv0; i++) begin
        @(negedge clk); #1;
      end
      chk("valid_count", 32'(n_valid - nv0), 32'd1);
      @(negedge clk); #1;
      chk("valid_one_cycle", 32'(mode_valid), 32'd0);
    end
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    sensor_ack  = 1'b0;
    sensor_data = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(sensor_req), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_valid", 32'(mode_valid), 32'd0);
    chk("rst_avg", 32'(avg_temp), 32'd0);
    chk("rst_fault", 32'(sensor_fault), 32'd0);
    reset  = 1'b0;
    enable = 1'b1;

`ifdef KLIMA_AVG_EN
    do_sample(8'd20, 1'b0, 2'b00, 8'd0);
    chk("avg_mode_hold1", 32'(mode), 32'd0);
    do_sample(8'd21, 1'b0, 2'b00, 8'd0);
    do_sample(8'd21, 1'b0, 2'b00, 8'd0);
    chk("avg_mode_hold3", 32'(mode), 32'd0);
    do_sample(8'd21, 1'b1, 2'b01, 8'd20);
    // -1,-1,-1,-2 sums to -5; floor(-5/4) = -2, COLD holds.
    do_sample(8'hFF, 1'b0, 2'b00, 8'd0);
    do_sample(8'hFF, 1'b0, 2'b00, 8'd0);
    do_sample(8'hFF, 1'b0, 2'b00, 8'd0);
    do_sample(8'hFE, 1'b1, 2'b01, 8'hFE);
`else
    do_sample(8'd25, 1'b1, 2'b10, 8'd25);
    do_sample(8'd15, 1'b1, 2'b01, 8'd15);
    do_sample(8'd21, 1'b1, 2'b01, 8'd21);
    do_sample(8'd22, 1'b1, 2'b01, 8'd22);
    do_sample(8'd23, 1'b1, 2'b10, 8'd23);
    do_sample(8'd35, 1'b1, 2'b11, 8'd35);
    do_sample(8'd29, 1'b1, 2'b11, 8'd29);
    do_sample(8'd28, 1'b1, 2'b10, 8'd28);
    do_sample(8'd35, 1'b1, 2'b11, 8'd35);
    do_sample(8'h80, 1'b1, 2'b01, 8'h80);

    // Timeout: request must hold for 63 edges and drop on the 64th.
    wait_req();
    repeat (63) @(negedge clk);
    #1;
    chk("tmo_req_held", 32'(sensor_req), 32'd1);
    chk("tmo_fault_pre", 32'(sensor_fault), 32'd0);
    @(negedge clk); #1;
    chk("tmo_req_drop", 32'(sensor_req), 32'd0);
    chk("tmo_fault", 32'(sensor_fault), 32'd1);
    chk("tmo_mode", 32'(mode), 32'd0);
    do_sample(8'd35, 1'b1, 2'b11, 8'd35);
    chk("fault_cleared", 32'(sensor_fault), 32'd0);

    // Enable dropped mid-request.
    wait_req();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk); #1;
    chk("dis_req", 32'(sensor_req), 32'd0);
    chk("dis_mode", 32'(mode), 32'd3);
    chk("dis_avg", 32'(avg_temp), 32'd35);
    enable = 1'b1;

    // Reset mid-request must drop outputs without a clock edge.
    wait_req();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_req", 32'(sensor_req), 32'd0);
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_valid", 32'(mode_valid), 32'd0);
    chk("arst_avg", 32'(avg_temp), 32'd0);
    chk("arst_fault", 32'(sensor_fault), 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    repeat (5) @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/klima_zamanlayici.md
KLIMA_ZAMANLAYICI -- requirements
Module: klima_zamanlayici

Interface
REQ-001 The block SHALL have parameter SAMPLE_PERIOD, default 1000, meaning idle cycles between sample requests (range 2..65535).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, meaning maximum cycles `sensor_req` waits for `sensor_ack` (range 1..255).
REQ-003 The block SHALL have parameter LOW_TH, default 20, meaning the signed cold/comfort threshold in degrees C.
REQ-004 The block SHALL have parameter HIGH_TH, default 30, meaning the signed comfort/hot threshold in degrees C.
REQ-005 The block SHALL have parameter HYST, default 2, meaning the hysteresis band in degrees C (0..(HIGH_TH-LOW_TH)/2).
REQ-006 The block SHALL have port `clk`, input, 1 bit: the clock.
REQ-007 The block SHALL have port `reset`, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have port `enable`, input, 1 bit: run the sampling schedule.
REQ-009 The block SHALL have port `sensor_req`, output, 1 bit: sample request to the sensor.
REQ-010 The block SHALL have port `sensor_ack`, input, 1 bit: sensor data valid.
REQ-011 The block SHALL have port `sensor_data`, input, 8 bits: signed two's-complement temperature.
REQ-012 The block SHALL have port `mode`, output, 2 bits: climate mode (00 OFF, 01 COLD/blue, 10 COMFORT/green, 11 HOT/red).
REQ-013 The block SHALL have port `mode_valid`, output, 1 bit: one-cycle pulse per decision.
REQ-014 The block SHALL have port `avg_temp`, output, 8 bits: signed filtered temperature used for the last decision.
REQ-015 The block SHALL have port `sensor_fault`, output, 1 bit: sticky timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, REQUEST, DECIDE.
- IDLE -> WAIT when `enable`=1.
- WAIT counts SAMPLE_PERIOD cycles, then -> REQUEST.
- REQUEST -> WAIT or DECIDE, as defined below.
- DECIDE -> WAIT after one cycle.
REQ-017 `sensor_req` SHALL be 1 exactly while in REQUEST and SHALL deassert on the clock edge that samples `sensor_ack`=1.
REQ-018 `sensor_data` SHALL be captured on the same edge that samples `sensor_ack`=1; `sensor_ack` outside REQUEST SHALL be ignored.
REQ-019 If `sensor_ack` is not seen within TIMEOUT cycles of entering REQUEST, the block SHALL do all of the following on that edge:
- set `sensor_fault`=1;
- force `mode`=00;
- clear the sample accumulator;
- go to WAIT.
REQ-020 `sensor_fault` SHALL clear on the next accepted ack.
REQ-021 After each accepted sample the FSM SHALL go to DECIDE when the sample set is complete (see Configuration), else to WAIT.
REQ-022 From OFF, DECIDE SHALL classify directly:
- avg<=LOW_TH -> 01;
- avg<=HIGH_TH -> 10;
- otherwise -> 11.
REQ-023 From COLD, DECIDE SHALL move to 11 if avg>HIGH_TH, else to 10 if avg>LOW_TH+HYST, else hold.
REQ-024 From COMFORT, DECIDE SHALL move to 01 if avg<=LOW_TH, to 11 if avg>HIGH_TH, else hold.
REQ-025 From HOT, DECIDE SHALL move to 01 if avg<=LOW_TH, else to 10 if avg<=HIGH_TH-HYST, else hold.
REQ-026 `mode` and `avg_temp` SHALL update on the edge leaving DECIDE, and `mode_valid` SHALL be 1 for exactly the following cycle.
REQ-027 All threshold comparisons SHALL be signed; -128 and +127 SHALL classify without overflow.
REQ-028 If `enable` falls, the block SHALL do all of the following on the next edge, regardless of state:
- go to IDLE;
- drop `sensor_req`;
- clear the accumulator and counters;
- hold `mode`, `avg_temp` and `sensor_fault`.
REQ-029 An ack and a timeout on the same cycle SHALL resolve as an accepted ack.

Reset
REQ-030 On `reset`=1, the block SHALL asynchronously enter IDLE with the following values:
- `sensor_req`=0, `mode`=00, `mode_valid`=0;
- `avg_temp`=0, `sensor_fault`=0;
- accumulator and all counters cleared.
REQ-031 Reset asserted mid-REQUEST SHALL drop `sensor_req` immediately, without waiting for a clock edge.

Configuration
REQ-032 With macro KLIMA_AVG_EN defined, a sample set SHALL be 4 accepted samples, with avg = (10-bit signed sum) arithmetic-shifted right by 2 (floor).
REQ-033 Without KLIMA_AVG_EN, a sample set SHALL be 1 sample, with avg = sample.

Verification
REQ-034 The bench SHALL cover these directed scenarios (default parameters, KLIMA_AVG_EN undefined, ack 3 cycles after req):
- Sample 25 from OFF -> `mode`=10, `avg_temp`=25, `mode_valid` pulses once.
- In COLD, samples 21, 22, 23 -> `mode` stays 01 after 21 and 22, becomes 10 after 23.
- In HOT, sample 29 -> holds 11; sample 28 -> 10; then sample -128 -> 01.
- Ack withheld for 64 cycles -> `sensor_fault`=1 and `mode`=00 on that edge; next acked 35 -> `sensor_fault`=0 and `mode`=11.
- `enable` dropped during REQUEST -> `sensor_req`=0 next cycle, `mode` unchanged; `reset` mid-REQUEST -> all outputs at reset values.
- With KLIMA_AVG_EN defined, samples 20, 21, 21, 21 -> `avg_temp`=20, `mode`=01, with a single `mode_valid` pulse after the 4th ack.
